bus_arbiter8_16: RTL and testbench
==================================

Name: bus_arbiter8_16

Overview:
- Round-robin arbiter/scheduler for the shared 16-bit 8:1 bus mux (mux8_1_16) in the single-cycle CPU.
- Up to 8 requesters (DMA, debug port, peripheral units) present 16-bit words. The arbiter chooses one, drives the mux select and captures the selected word into a registered output stage.
- The output stage uses a valid/ready handshake toward the consumer, such as the register-file write port or the memory bus.

Parameters:
- NREQ, 8, number of requesters; fixed at 8, matching the 3-bit mux select.
- DW, 16, data width; fixed at 16, matching the mux.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  req[i]=1: requester i has a word pending on d_i.
- d0..d7  input  16 each  requester data, fed to the mux inputs i0..i7.
- gnt  output  8  one-hot capture acknowledge; combinational; high in the cycle d_i is captured.
- sel  output  3  mux select currently driven; registered.
- out_data  output  16  captured word; registered.
- out_src  output  3  index of the requester that supplied out_data; registered.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_src=0, sel=0, last=7, state=IDLE. gnt=0 while rst=1. Reset overrides all other events, including mid-transfer; a pending word is dropped.
- Round-robin search: start at (last+1) mod 8 and ascend with wrap-around. winner = first index with req set. last=7 gives priority order 0,1,…,7.
- "Slot free" means: state=IDLE, or (state=FULL && out_ready=1).
- Capture condition: slot free && |req. In a capture cycle:
  - gnt[winner]=1 combinationally;
  - sel is driven to winner through a combinational bypass, so the mux output is the winner's data in that same cycle;
  - at the edge: out_data<=d_winner, out_src<=winner, sel<=winner, last<=winner, out_valid<=1, state<=FULL.
- States:
  - IDLE: no word held. Capture condition → FULL; otherwise stay in IDLE.
  - FULL: word held.
    - out_ready=0 → hold out_data/out_src/out_valid stable; gnt=0.
    - out_ready=1 && |req → back-to-back: accept the current word and capture the next one in the same cycle. out_valid stays 1.
    - out_ready=1 && req=0 → out_valid<=0, state<=IDLE.
- Latency: req asserted in cycle N with slot free → out_valid in cycle N+1. Sustained throughput is 1 word/clock.
- Requester rule: hold req[i] and d_i stable until the cycle gnt[i]=1. Deassert req[i] or change d_i in the next cycle, or keep req[i] high to present a new word.
- Fairness: a requester that just won has the lowest priority next time. Any continuously asserted req is served within 8 captures.
- No capture occurs while FULL && out_ready=0; all gnt=0.
- sel holds its last value while idle.

Optional Feature:
- Macro: BUS_ARBITER_LOCK_EN.
- Defined:
  - adds input port lock (8 bits);
  - if lock[last]=1 and req[last]=1 at a capture opportunity, winner=last and rotation is suppressed (burst hold);
  - lock[i] has no effect unless i==last.
- Undefined: the lock port does not exist and arbitration is pure round-robin.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF → gnt=0, out_valid=0, out_data=0, sel=0; after release, first gnt=8'h01 and out_data=d0.
- Single requester: req=8'h08, d3=16'hBEEF, out_ready=1 → gnt=8'h08 in cycle N; out_valid=1, out_data=16'hBEEF, out_src=3 in cycle N+1.
- Rotation: req=8'hFF held, di=i*16'h1111, out_ready=1 → out_src sequence 0,1,…,7,0 on consecutive cycles; out_valid stays 1 throughout.
- Backpressure: req=8'h21, out_ready=0 for 5 cycles after the first capture → out_data=d0 held stable and gnt=0 for 5 cycles; after out_ready=1, next out_src=5.
- Wrap/pointer: last=6 and req=8'h41 → winner=0, not 6; then with req=8'h40 → winner=6.
- Reset mid-transfer: out_valid=1 with out_ready=0, assert rst → out_valid=0 next cycle and the next grant restarts at requester 0. With BUS_ARBITER_LOCK_EN defined, additionally: lock[2]=1, req=8'h06 → out_src=2,2,2 until lock[2]=0, then 1.

Source files
------------

// File: rtl/bus_arbiter8_16.sv
// bus_arbiter8_16: round-robin arbiter in front of the shared 16-bit 8:1 bus
// mux. It picks one requester, drives the mux select and captures the chosen
// word into a one-deep output register with a valid/ready handshake.
// The output register accepts a new word in the same cycle the old one is
// consumed, so the sustained rate is one word per clock.
// Optional build macro BUS_ARBITER_LOCK_EN adds an 8-bit lock input: while
// the previous winner has both its lock bit and its req bit set, it keeps the
// grant (burst hold).
module bus_arbiter8_16 #(
  parameter int NREQ = 8,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef BUS_ARBITER_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   d0,
  input  logic [DW-1:0]   d1,
  input  logic [DW-1:0]   d2,
  input  logic [DW-1:0]   d3,
  input  logic [DW-1:0]   d4,
  input  logic [DW-1:0]   d5,
  input  logic [DW-1:0]   d6,
  input  logic [DW-1:0]   d7,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      sel,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      last_q, last_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      src_q, src_d;
  logic [DW-1:0]   data_q, data_d;

  logic [2:0]      winner;
  logic [2:0]      idx;
  logic            found;
  logic            slot_free;
  logic            capture;
  logic [DW-1:0]   mux_out;

  // Round-robin search starting just after the last winner, wrapping at 8.
  // The lock option lets the last winner keep the bus while it holds lock.
  always_comb begin
    winner = last_q;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_q + 3'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`ifdef BUS_ARBITER_LOCK_EN
    if (lock[last_q] && req[last_q]) winner = last_q;
`endif
  end

  // A capture needs room in the output register (empty, or being drained
  // this cycle) and at least one request; reset blocks all grants.
  always_comb begin
    slot_free = (state_q == IDLE) || out_ready;
    capture   = slot_free && (|req) && !rst;
    gnt       = '0;
    if (capture) gnt[winner] = 1'b1;
    // Bypass the select so the mux shows the winner's data in the grant cycle.
    sel       = capture ? winner : sel_q;
  end

  // The 8:1 data mux, steered by the (bypassed) select.
  always_comb begin
    mux_out = d0;
    case (sel)
      3'd0: mux_out = d0;
      3'd1: mux_out = d1;
      3'd2: mux_out = d2;
      3'd3: mux_out = d3;
      3'd4: mux_out = d4;
      3'd5: mux_out = d5;
      3'd6: mux_out = d6;
      3'd7: mux_out = d7;
      default: mux_out = d0;
    endcase
  end

  // Next state: capture loads the output stage, a drain with no new
  // request empties it, otherwise everything holds.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    src_d   = src_q;
    data_d  = data_q;
    if (capture) begin
      state_d = FULL;
      last_d  = winner;
      sel_d   = winner;
      src_d   = winner;
      data_d  = mux_out;
    end else if (state_q == FULL && out_ready) begin
      state_d = IDLE;
    end
  end

  // State registers; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      sel_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_bus_arbiter8_16.sv
// Self-checking bench for bus_arbiter8_16: directed scenarios plus a random
// run, all compared against a transaction-level model of the arbiter.
module tb_bus_arbiter8_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  req = '0;
  logic [7:0]  lock = '0;
  logic [15:0] d [8];
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic [15:0] out_data;
  logic [2:0]  out_src;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model: one-slot holding register plus round-robin pointer.
  logic        m_valid = 1'b0;
  logic [15:0] m_data = '0;
  logic [2:0]  m_src = '0;
  logic [2:0]  m_sel = '0;
  int          m_last = 7;

  always #5 clk = ~clk;

  bus_arbiter8_16 dut (
    .clk(clk), .rst(rst),
`ifdef BUS_ARBITER_LOCK_EN
    .lock(lock),
`endif
    .req(req),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .gnt(gnt), .sel(sel), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Winner by the arbitration rules; -1 when nobody requests.
  function automatic int pick(logic [7:0] r, int last, logic [7:0] lk);
`ifdef BUS_ARBITER_LOCK_EN
    if (lk[last] && r[last]) return last;
`endif
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction

  function automatic logic model_capture();
    return !rst && (pick(req, m_last, lock) >= 0) && (!m_valid || out_ready);
  endfunction

  function automatic logic [7:0] model_gnt();
    logic [7:0] g;
    g = '0;
    if (model_capture()) g[pick(req, m_last, lock)] = 1'b1;
    return g;
  endfunction

  function automatic logic [2:0] model_sel();
    return model_capture() ? 3'(pick(req, m_last, lock)) : m_sel;
  endfunction

  // Advance one clock and update the model from the inputs held over the edge.
  task automatic tick();
    int w;
    logic cap;
    w   = pick(req, m_last, lock);
    cap = model_capture();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = 0; m_sel = 0; m_last = 7;
    end else if (cap) begin
      m_valid = 1; m_data = d[w]; m_src = 3'(w); m_sel = 3'(w); m_last = w;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 8'hFF; out_ready = 1;
    for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
    tick(); tick();
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got %h exp 00", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
    rst = 0; #1;
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL reset_first_gnt got %h exp 01", gnt); end
    tick();
    checks++; if (out_data !== d[0] || out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_data got %h/%b exp %h/1", out_data, out_valid, d[0]); end
  endtask

  task automatic test_single();
    req = 8'h08; d[3] = 16'hBEEF; out_ready = 1; #1;
    checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL single_gnt got %h exp 08", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_src !== 3'd3) begin
      errors++; $display("FAIL single_out got v=%b d=%h s=%0d exp v=1 d=beef s=3", out_valid, out_data, out_src); end
    req = 8'h00; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 8; i++) d[i] = 16'(i * 16'h1111);
    req = 8'hFF; out_ready = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 3'(k % 8) || out_data !== 16'((k % 8) * 16'h1111)) begin
        errors++; $display("FAIL rotation_%0d got v=%b s=%0d d=%h exp v=1 s=%0d", k, out_valid, out_src, out_data, k % 8); end
    end
    req = 0; tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] d0v;
    do_reset();
    d0v = 16'h1234; d[0] = d0v; d[5] = 16'h5555;
    req = 8'h21; out_ready = 1; tick();
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL bp_gnt_%0d got %h exp 00", k, gnt); end
      tick();
      checks++; if (out_data !== d0v || out_valid !== 1'b1 || out_src !== 3'd0) begin
        errors++; $display("FAIL bp_hold_%0d got d=%h v=%b exp d=%h v=1", k, out_data, out_valid, d0v); end
    end
    out_ready = 1; #1;
    checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL bp_resume_gnt got %h exp 20", gnt); end
    tick();
    checks++; if (out_src !== 3'd5) begin errors++; $display("FAIL bp_resume_src got %0d exp 5", out_src); end
    req = 0; tick();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1; req = 8'h40; tick();
    req = 8'h41; #1;
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL wrap_gnt got %h exp 01", gnt); end
    tick();
    checks++; if (out_src !== 3'd0) begin errors++; $display("FAIL wrap_src got %0d exp 0", out_src); end
    req = 8'h40; tick();
    checks++; if (out_src !== 3'd6) begin errors++; $display("FAIL wrap_src6 got %0d exp 6", out_src); end
    req = 0; tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1; req = 8'h10; tick();
    out_ready = 0; req = 8'hFF; tick();
    rst = 1; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    rst = 0; out_ready = 1; #1;
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL midrst_gnt got %h exp 01", gnt); end
    req = 0; tick(); tick();
  endtask

`ifdef BUS_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    out_ready = 1; req = 8'h04; tick();
    lock = 8'h04; req = 8'h06;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_src !== 3'd2) begin errors++; $display("FAIL lock_hold_%0d got %0d exp 2", k, out_src); end
    end
    lock = 8'h00; tick();
    checks++; if (out_src !== 3'd1) begin errors++; $display("FAIL lock_release got %0d exp 1", out_src); end
    req = 0; tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      req = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      lock = 8'($urandom);
      for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
      #1;
      checks++; if (gnt !== model_gnt() || sel !== model_sel()) begin
        errors++; $display("FAIL rand_gnt_%0d got g=%h s=%0d exp g=%h s=%0d", n, gnt, sel, model_gnt(), model_sel()); end
      tick();
      checks++; if (out_valid !== m_valid || out_src !== m_src || out_data !== m_data) begin
        errors++; $display("FAIL rand_out_%0d got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
                           n, out_valid, out_src, out_data, m_valid, m_src, m_data); end
    end
    rst = 0; lock = 0; req = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i] = '0;
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef BUS_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
